// File: rtl/cel_row_sequencer.sv
// Packed-cel row sequencer: walks the row headers of a cel in memory, starts the
// unpacker once per row and paces pixel delivery against the downstream sink.
module cel_row_sequencer #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 11
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cel_start,
  input  logic [ADDR_W-1:0] cel_addr,
  input  logic [CNT_W-1:0]  cel_rows,
  input  logic [CNT_W-1:0]  cel_width,
  input  logic [2:0]        bpp,
  input  logic [31:0]       dma_data,
  output logic [ADDR_W-1:0] dma_addr,
  output logic              up_start,
  input  logic              up_rd_req,
  input  logic              up_eol,
  output logic              up_next_pix,
  input  logic              pix_ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  row_idx
);

  typedef enum logic [2:0] {
    IDLE,
    ROW_START,
    HDR,
    PIXELS,
    ROW_END,
    DONE
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] dmaAddr_q;
  logic [ADDR_W-1:0] rowAddr_q;
  logic [9:0]        offset_q;
  logic [CNT_W-1:0]  rowIdx_q;
  logic [CNT_W-1:0]  pixCnt_q;
  logic [CNT_W-1:0]  rows_q;
  logic [CNT_W-1:0]  width_q;
  logic [2:0]        bpp_q;
  logic              upStart_q;
  logic              busy_q;
  logic              done_q;

  logic [9:0]        hdrOffset_d;
  logic [ADDR_W-1:0] rowStep_d;
  logic              pixLast_d;
  logic              rowDone_d;
  logic              lastRow_d;
  logic              unusedHdrBits;

  // The deep pixel formats keep a 10-bit offset lower in the header word.
  assign hdrOffset_d = (bpp_q == 3'd5 || bpp_q == 3'd6) ? dma_data[25:16]
                                                        : {2'b00, dma_data[31:24]};
  assign unusedHdrBits = ^dma_data[15:0];

  assign rowStep_d = ADDR_W'({offset_q, 2'b00}) + ADDR_W'(8);
  assign pixLast_d = (width_q != '0) && (pixCnt_q == width_q - CNT_W'(1));
  assign lastRow_d = (rowIdx_q == rows_q - CNT_W'(1));

  assign up_next_pix = (state_q == PIXELS) && pix_ready;
  assign rowDone_d   = up_eol || (up_next_pix && pixLast_d);

  assign dma_addr = dmaAddr_q;
  assign up_start = upStart_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign row_idx  = rowIdx_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      dmaAddr_q <= '0;
      rowAddr_q <= '0;
      offset_q  <= '0;
      rowIdx_q  <= '0;
      pixCnt_q  <= '0;
      rows_q    <= '0;
      width_q   <= '0;
      bpp_q     <= '0;
      upStart_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      upStart_q <= 1'b0;
      done_q    <= 1'b0;
      if (up_rd_req && state_q != IDLE) dmaAddr_q <= dmaAddr_q + ADDR_W'(4);

      case (state_q)
        IDLE: begin
          if (cel_start) begin
            rows_q    <= cel_rows;
            width_q   <= cel_width;
            bpp_q     <= bpp;
            dmaAddr_q <= cel_addr;
            rowAddr_q <= cel_addr;
            rowIdx_q  <= '0;
            busy_q    <= 1'b1;
            state_q   <= (cel_rows == '0) ? DONE : ROW_START;
          end
        end
        ROW_START: begin
          upStart_q <= 1'b1;
          // A word consumed while the row is being launched still counts.
          dmaAddr_q <= up_rd_req ? rowAddr_q + ADDR_W'(4) : rowAddr_q;
          pixCnt_q  <= '0;
          state_q   <= HDR;
        end
        HDR: begin
          if (up_rd_req) begin
            offset_q <= hdrOffset_d;
            state_q  <= PIXELS;
          end
        end
        PIXELS: begin
          if (up_next_pix) pixCnt_q <= pixCnt_q + CNT_W'(1);
          if (rowDone_d) state_q <= ROW_END;
        end
        ROW_END: begin
          rowAddr_q <= rowAddr_q + rowStep_d;
          if (lastRow_d) begin
            state_q <= DONE;
          end else begin
            rowIdx_q <= rowIdx_q + CNT_W'(1);
            state_q  <= ROW_START;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cel_row_sequencer.sv
// Directed self-checking bench for cel_row_sequencer; the bench plays the
// unpacker and the pixel sink, expected values are worked out by hand.
module tb_cel_row_sequencer;

  logic        clock;
  logic        reset;
  logic        cel_start;
  logic [31:0] cel_addr;
  logic [10:0] cel_rows;
  logic [10:0] cel_width;
  logic [2:0]  bpp;
  logic [31:0] dma_data;
  logic [31:0] dma_addr;
  logic        up_start;
  logic        up_rd_req;
  logic        up_eol;
  logic        up_next_pix;
  logic        pix_ready;
  logic        busy;
  logic        done;
  logic [10:0] row_idx;

  int checkCount = 0;
  int passCount  = 0;

  int          startCnt;
  int          pixCnt;
  int          doneCnt;
  int          doneCycle;
  logic        busyAtDone;
  logic [31:0] startAddr [4];
  logic [10:0] startRow  [4];

  cel_row_sequencer #(.ADDR_W(32), .CNT_W(11)) dut (
    .clock       (clock),
    .reset       (reset),
    .cel_start   (cel_start),
    .cel_addr    (cel_addr),
    .cel_rows    (cel_rows),
    .cel_width   (cel_width),
    .bpp         (bpp),
    .dma_data    (dma_data),
    .dma_addr    (dma_addr),
    .up_start    (up_start),
    .up_rd_req   (up_rd_req),
    .up_eol      (up_eol),
    .up_next_pix (up_next_pix),
    .pix_ready   (pix_ready),
    .busy        (busy),
    .done        (done),
    .row_idx     (row_idx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Pulses cel_start for one cycle; returns just after the edge that sampled it.
  task automatic applyStimulus(input logic [31:0] addr, input logic [10:0] rows,
                               input logic [10:0] width, input logic [2:0] fmt);
    cel_addr  = addr;
    cel_rows  = rows;
    cel_width = width;
    bpp       = fmt;
    cel_start = 1'b1;
    tick();
    cel_start = 1'b0;
  endtask

  // Acts as the unpacker until done: consumes the header word on every up_start.
  task automatic runCel(input logic [31:0] header, input int budget);
    startCnt   = 0;
    pixCnt     = 0;
    doneCnt    = 0;
    doneCycle  = -1;
    busyAtDone = 1'b1;
    pix_ready  = 1'b1;
    for (int cyc = 0; cyc < budget && doneCnt == 0; cyc++) begin
      if (up_start && startCnt < 4) begin
        startAddr[startCnt] = dma_addr;
        startRow[startCnt]  = row_idx;
      end
      if (up_start) startCnt++;
      up_rd_req = up_start;
      dma_data  = header;
      #1;
      if (up_next_pix) pixCnt++;
      if (done) begin
        doneCnt++;
        doneCycle  = cyc;
        busyAtDone = busy;
      end
      tick();
    end
    up_rd_req = 1'b0;
  endtask

  task automatic resetDut();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int pulses;
    int trackErr;
    int extraDone;
    logic found;

    reset     = 1'b0;
    cel_start = 1'b0;
    cel_addr  = '0;
    cel_rows  = '0;
    cel_width = '0;
    bpp       = '0;
    dma_data  = '0;
    up_rd_req = 1'b0;
    up_eol    = 1'b0;
    pix_ready = 1'b1;
    tick();
    resetDut();

    checkOutput("rstBusy",     busy,        0);
    checkOutput("rstDone",     done,        0);
    checkOutput("rstUpStart",  up_start,    0);
    checkOutput("rstDmaAddr",  dma_addr,    0);
    checkOutput("rstRowIdx",   row_idx,     0);
    checkOutput("idleNextPix", up_next_pix, 0);

    $display("[TB] single row, width 4");
    applyStimulus(32'h1000, 11'd1, 11'd4, 3'd3);
    checkOutput("s1BusyAfterStart", busy, 1);
    runCel(32'h02AA_BBCC, 40);
    checkOutput("s1StartCount", startCnt, 1);
    checkOutput("s1StartAddr",  startAddr[0], 32'h1000);
    checkOutput("s1PixCount",   pixCnt, 4);
    checkOutput("s1DoneCount",  doneCnt, 1);
    checkOutput("s1DoneCycle",  doneCycle, 8);
    checkOutput("s1BusyAtDone", busyAtDone, 0);

    $display("[TB] three rows, offset 5");
    applyStimulus(32'h1000, 11'd3, 11'd2, 3'd3);
    runCel(32'h0500_0000, 80);
    checkOutput("s2StartCount", startCnt, 3);
    checkOutput("s2Addr0", startAddr[0], 32'h1000);
    checkOutput("s2Addr1", startAddr[1], 32'h101C);
    checkOutput("s2Addr2", startAddr[2], 32'h1038);
    checkOutput("s2Row0",  startRow[0], 0);
    checkOutput("s2Row1",  startRow[1], 1);
    checkOutput("s2Row2",  startRow[2], 2);
    checkOutput("s2PixCount", pixCnt, 6);
    extraDone = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) extraDone++;
      tick();
    end
    checkOutput("s2DoneCount", doneCnt + extraDone, 1);

    $display("[TB] header offset formats and address wrap");
    applyStimulus(32'h2000, 11'd2, 11'd1, 3'd6);
    runCel(32'hFC03_0000, 40);
    checkOutput("bpp6Addr1", startAddr[1], 32'h2014);
    applyStimulus(32'h3000, 11'd2, 11'd1, 3'd5);
    runCel(32'h01FF_0000, 40);
    checkOutput("bpp5Addr1", startAddr[1], 32'h3804);
    applyStimulus(32'hFFFF_FFF0, 11'd2, 11'd1, 3'd3);
    runCel(32'h0200_0000, 40);
    checkOutput("wrapAddr1", startAddr[1], 32'h0000_0000);

    $display("[TB] width 0, row ends on eol, toggled pix_ready");
    applyStimulus(32'h4000, 11'd1, 11'd0, 3'd3);
    pix_ready = 1'b1;
    #1;
    checkOutput("nextPixRowStart", up_next_pix, 0);
    tick();
    up_rd_req = 1'b1;
    dma_data  = 32'h0;
    #1;
    checkOutput("nextPixHdr", up_next_pix, 0);
    tick();
    up_rd_req = 1'b0;
    pulses   = 0;
    trackErr = 0;
    for (int i = 0; i < 13; i++) begin
      pix_ready = (i % 2 == 0);
      #1;
      if (up_next_pix) pulses++;
      if (up_next_pix !== pix_ready) trackErr++;
      tick();
    end
    checkOutput("eolPulses",   pulses, 7);
    checkOutput("eolTrackErr", trackErr, 0);
    pix_ready = 1'b0;
    up_eol    = 1'b1;
    tick();
    up_eol    = 1'b0;
    pix_ready = 1'b1;
    #1;
    checkOutput("nextPixRowEnd", up_next_pix, 0);
    checkOutput("eolDmaAddr",    dma_addr, 32'h4004);
    tick();
    tick();
    checkOutput("eolDone", done, 1);

    $display("[TB] zero rows and ignored restart");
    applyStimulus(32'h4400, 11'd0, 11'd3, 3'd3);
    checkOutput("zeroRowsDoneEarly", done, 0);
    checkOutput("zeroRowsBusy1", busy, 1);
    tick();
    checkOutput("zeroRowsDone", done, 1);
    checkOutput("zeroRowsBusy0", busy, 0);
    checkOutput("zeroRowsNoStart", up_start, 0);
    applyStimulus(32'h5000, 11'd1, 11'd2, 3'd3);
    cel_start = 1'b1;
    cel_addr  = 32'h6000;
    cel_rows  = 11'd0;
    tick();
    cel_start = 1'b0;
    checkOutput("ignUpStart", up_start, 1);
    checkOutput("ignDmaAddr", dma_addr, 32'h5000);
    checkOutput("ignBusy",    busy, 1);
    runCel(32'h0, 40);
    checkOutput("ignStartAddr", startAddr[0], 32'h5000);
    checkOutput("ignPixCount",  pixCnt, 2);
    checkOutput("ignDoneCount", doneCnt, 1);

    $display("[TB] reset in the middle of row 1");
    applyStimulus(32'h7000, 11'd3, 11'd4, 3'd3);
    pix_ready = 1'b1;
    found     = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      up_rd_req = up_start;
      dma_data  = 32'h0100_0000;
      if (up_start && row_idx == 11'd1) found = 1'b1;
      tick();
    end
    up_rd_req = 1'b0;
    checkOutput("reachRow1", found, 1);
    #1;
    checkOutput("midRowNextPix", up_next_pix, 1);
    checkOutput("midRowIdx",     row_idx, 1);
    checkOutput("midRowDmaAddr", dma_addr, 32'h7010);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checkOutput("midRstBusy",     busy, 0);
    checkOutput("midRstDone",     done, 0);
    checkOutput("midRstUpStart",  up_start, 0);
    checkOutput("midRstDmaAddr",  dma_addr, 0);
    checkOutput("midRstRowIdx",   row_idx, 0);
    checkOutput("midRstNextPix",  up_next_pix, 0);
    tick();
    applyStimulus(32'h8000, 11'd1, 11'd1, 3'd3);
    runCel(32'h0300_0000, 40);
    checkOutput("restartRow",   startRow[0], 0);
    checkOutput("restartAddr",  startAddr[0], 32'h8000);
    checkOutput("restartPix",   pixCnt, 1);
    checkOutput("restartDone",  doneCnt, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation did not finish");
  end

endmodule

// File: doc/cel_row_sequencer.md
CEL_ROW_SEQUENCER -- requirements
Module: cel_row_sequencer

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width of dma_addr and cel_addr.
REQ-002 Parameter CNT_W, default 11, width of the pixel and row counters.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cel_start  input  1  one-cycle request to begin a packed cel.
REQ-006 cel_addr  input  ADDR_W  byte address of the first row header word, word-aligned.
REQ-007 cel_rows  input  CNT_W  number of rows; 0 means no rows.
REQ-008 cel_width  input  CNT_W  pixels per row; 0 means the row ends only on up_eol.
REQ-009 bpp  input  3  pixel format code shared with the unpacker; 5 = 8bpp, 6 = 16bpp.
REQ-010 dma_data  input  32  memory read data for dma_addr, valid in the same cycle as up_rd_req.
REQ-011 dma_addr  output  ADDR_W  current read address presented to memory and the unpacker.
REQ-012 up_start  output  1  start pulse to the unpacker.
REQ-013 up_rd_req  input  1  unpacker word-consume strobe.
REQ-014 up_eol  input  1  unpacker end-of-line pulse.
REQ-015 up_next_pix  output  1  pixel advance to the unpacker.
REQ-016 pix_ready  input  1  downstream pixel sink can accept a pixel this cycle.
REQ-017 busy  output  1  high from the accepted cel_start until done.
REQ-018 done  output  1  one-cycle pulse when the cel completes.
REQ-019 row_idx  output  CNT_W  index of the row currently being sequenced.

Function
REQ-020 States: IDLE, ROW_START, HDR, PIXELS, ROW_END, DONE. All outputs are registered except up_next_pix.
REQ-021 IDLE + cel_start:
- latch cel_rows, cel_width, bpp
- row_addr = dma_addr = cel_addr; row_idx = 0; busy = 1
- go to DONE if cel_rows == 0, else ROW_START.
REQ-022 cel_start outside IDLE is ignored, with no effect on any state.
REQ-023 ROW_START, one cycle:
- up_start = 1; dma_addr = row_addr; pix_cnt = 0
- go to HDR.
REQ-024 Any cycle with up_rd_req = 1: dma_addr increments by 4 on the next edge, wrapping modulo 2^ADDR_W.
REQ-025 HDR waits for the first up_rd_req. In that cycle, capture the row offset:
- bpp 5 or 6: dma_data[25:16]
- otherwise: {2'b00, dma_data[31:24]}
- then go to PIXELS.
REQ-026 PIXELS: up_next_pix = pix_ready, combinational. Each asserted cycle increments pix_cnt.
REQ-027 PIXELS ends on up_eol, or on up_next_pix with pix_cnt == cel_width-1 while cel_width != 0; either goes to ROW_END. If both occur in the same cycle, one row end is taken.
REQ-028 up_next_pix is 0 in every state except PIXELS.
REQ-029 ROW_END, one cycle:
- row_addr += (offset + 2) * 4; offset is zero-extended and the sum wraps.
- row_idx == cel_rows-1: go to DONE.
- otherwise: row_idx += 1 and go to ROW_START.
REQ-030 DONE, one cycle: done = 1 and busy = 0 on the next edge, then go to IDLE.
REQ-031 up_rd_req or up_eol seen in IDLE, ROW_START, ROW_END or DONE does not change state. An up_rd_req still advances dma_addr (REQ-024) except in IDLE.

Reset
REQ-032 With reset = 1 at an edge, the block goes to IDLE:
- dma_addr, row_addr and offset = 0
- row_idx and pix_cnt = 0
- up_start, busy and done = 0
REQ-033 Reset overrides every other input in that cycle, including mid-row. The unpacker is not signalled.

Verification
REQ-034 Start with cel_addr=0x1000, rows=1, width=4, bpp=3, header 0x02xx_xxxx, pix_ready=1 -> up_start once; dma_addr 0x1000 at the first rd_req; 4 next_pix pulses; done 1 cycle later; busy low after done.
REQ-035 rows=3, header offset 0x05 on each row -> up_start seen at row_addr 0x1000, 0x101C, 0x1038; row_idx 0,1,2; exactly one done.
REQ-036 bpp=6, header 0x0003_xxxx -> offset=3; next row_addr = base + 20.
REQ-037 width=0, up_eol after 7 next_pix -> ROW_END on the eol cycle. With pix_ready toggled 1/0, next_pix tracks pix_ready only in PIXELS.
REQ-038 cel_start with rows=0 -> done 2 cycles after start, no up_start. A second cel_start while busy is ignored.
REQ-039 Reset asserted in PIXELS of row 1, then a new cel_start -> IDLE with all REQ-032 values, and the new cel restarts at row_idx 0.
